router_pkt_reg: RTL

ROUTER_PKT_REG -- requirements
Module: router_pkt_reg

---
 rtl/router_pkt_reg.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/router_pkt_reg.sv
// Router packet register: registers header/payload bytes toward the FIFO and checks packet parity.
// Optional payload-length check is built in when ROUTER_LEN_CHECK_EN is defined.
module router_pkt_reg #(
   parameter int DATA_W    = 8,
   parameter int NUM_PORTS = 3,
   parameter int ADDR_W    = 2
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              pkt_valid,
   input  logic              fifo_full,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              rst_int_reg,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              err,
   output logic              parity_done,
   output logic              low_packet_valid,
   output logic              len_err
);

   logic [DATA_W-1:0] r_header;
   logic [DATA_W-1:0] r_hold_byte;
   logic [DATA_W-1:0] r_int_parity;
   logic [DATA_W-1:0] r_pkt_parity;
   logic [DATA_W-1:0] r_dout;
   logic              r_hold_is_parity;
   logic              r_dout_valid;
   logic              r_err;
   logic              r_parity_done;
   logic              r_pd_prev;
   logic              r_low_pkt_valid;

   logic w_addr_ok;
   logic w_hdr_ok;
   logic w_ld_write;
   logic w_ld_stall;
   logic w_data_xor;
   logic w_hold_xor;
   logic w_pp_load_data;
   logic w_pp_load_hold;
   logic w_pp_load;
   logic w_pd_rise;
   logic w_unused_full;

   // full_state carries no information beyond fifo_full/laf_state for this block
   assign w_unused_full  = full_state;

   assign w_addr_ok      = (32'(data_in[ADDR_W-1:0]) < NUM_PORTS);
   assign w_hdr_ok       = detect_add & pkt_valid & w_addr_ok;
   assign w_ld_write     = ld_state & ~fifo_full;
   assign w_ld_stall     = ld_state & fifo_full;
   assign w_data_xor     = ld_state & pkt_valid & ~fifo_full;
   assign w_hold_xor     = laf_state & ~r_hold_is_parity;
   assign w_pp_load_data = ld_state & ~pkt_valid & ~fifo_full;
   assign w_pp_load_hold = laf_state & r_hold_is_parity;
   assign w_pp_load      = w_pp_load_data | w_pp_load_hold;
   assign w_pd_rise      = r_parity_done & ~r_pd_prev;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_header         <= '0;
         r_hold_byte      <= '0;
         r_hold_is_parity <= 1'b0;
         r_dout           <= '0;
         r_dout_valid     <= 1'b0;
      end else begin
         r_dout_valid <= 1'b0;
         if (w_hdr_ok)
            r_header <= data_in;
         if (lfd_state) begin
            r_dout       <= r_header;
            r_dout_valid <= 1'b1;
         end else if (w_ld_write) begin
            r_dout       <= data_in;
            r_dout_valid <= 1'b1;
         end else if (laf_state) begin
            r_dout       <= r_hold_byte;
            r_dout_valid <= 1'b1;
         end
         // A byte refused by a full FIFO is parked and replayed in laf_state
         if (w_ld_stall) begin
            r_hold_byte      <= data_in;
            r_hold_is_parity <= ~pkt_valid;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_int_parity    <= '0;
         r_pkt_parity    <= '0;
         r_parity_done   <= 1'b0;
         r_pd_prev       <= 1'b0;
         r_err           <= 1'b0;
         r_low_pkt_valid <= 1'b0;
      end else begin
         if (w_hdr_ok)
            r_int_parity <= '0;
         else if (lfd_state)
            r_int_parity <= r_int_parity ^ r_header;
         else if (w_data_xor)
            r_int_parity <= r_int_parity ^ data_in;
         else if (w_hold_xor)
            r_int_parity <= r_int_parity ^ r_hold_byte;

         if (w_pp_load_data)
            r_pkt_parity <= data_in;
         else if (w_pp_load_hold)
            r_pkt_parity <= r_hold_byte;
         else if (w_hdr_ok)
            r_pkt_parity <= '0;

         if (w_pp_load)
            r_parity_done <= 1'b1;
         else if (w_hdr_ok)
            r_parity_done <= 1'b0;

         r_pd_prev <= r_parity_done;

         // Compare one cycle after parity_done rises so both parities are settled
         if (w_hdr_ok)
            r_err <= 1'b0;
         else if (w_pd_rise)
            r_err <= (r_pkt_parity != r_int_parity);

         if (rst_int_reg)
            r_low_pkt_valid <= 1'b0;
         else if (ld_state & ~pkt_valid)
            r_low_pkt_valid <= 1'b1;
      end
   end

`ifdef ROUTER_LEN_CHECK_EN
   localparam int CNT_W = DATA_W - ADDR_W + 1;

   logic [CNT_W-1:0] r_pay_cnt;
   logic             r_len_err;
   logic             w_cnt_ev;

   assign w_cnt_ev = w_data_xor | w_hold_xor;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_pay_cnt <= '0;
         r_len_err <= 1'b0;
      end else begin
         if (w_hdr_ok)
            r_pay_cnt <= '0;
         else if (w_cnt_ev && (r_pay_cnt != {CNT_W{1'b1}}))
            r_pay_cnt <= r_pay_cnt + CNT_W'(1);

         if (w_hdr_ok)
            r_len_err <= 1'b0;
         else if (w_pd_rise)
            r_len_err <= (r_pay_cnt != {1'b0, r_header[DATA_W-1:ADDR_W]});
      end
   end

   assign len_err = r_len_err;
`else
   assign len_err = 1'b0;
`endif

   assign dout             = r_dout;
   assign dout_valid       = r_dout_valid;
   assign err              = r_err;
   assign parity_done      = r_parity_done;
   assign low_packet_valid = r_low_pkt_valid;

endmodule
